// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexes three character codes onto a 3-digit common-enable
// seven-segment display. Each digit slot lasts PRESCALE clocks, the first
// BLANK of which are dark to suppress ghosting. Character codes are shadowed
// once per frame so a scrolling source never tears mid-frame.
//
// Optional build macro SEG_DIM_EN: adds a 2-bit dim input that gates the
// drive phase with a 4-step duty cycle (dim=0 full, dim=3 one cycle in four).
//
// state | meaning
// ------+---------------------------------------------
// DIG0  | slot for the right digit  (hex0, digit_en[0])
// DIG1  | slot for the middle digit (hex1, digit_en[1])
// DIG2  | slot for the left digit   (hex2, digit_en[2])
module seven_seg_scan_driver #(
  parameter int PRESCALE = 4000,
  parameter int BLANK    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hex2,
  input  logic [4:0] hex1,
  input  logic [4:0] hex0,
`ifdef SEG_DIM_EN
  input  logic [1:0] dim,
`endif
  output logic [7:0] seg,
  output logic [2:0] digit_en,
  output logic       frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [4:0] CODE_BLANK = 5'd16;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } dig_t;

  dig_t          state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    sh0, sh1, sh2;
  logic          slot_end;
  logic          frame_end;
  logic          blank_ph;
  logic          dim_on;
  logic [4:0]    sel_code;

  // Active-high abcdefg glyph for a 5-bit character code.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'h3F;
      5'd1:    g = 7'h06;
      5'd2:    g = 7'h5B;
      5'd3:    g = 7'h4F;
      5'd4:    g = 7'h66;
      5'd5:    g = 7'h6D;
      5'd6:    g = 7'h7D;
      5'd7:    g = 7'h07;
      5'd8:    g = 7'h7F;
      5'd9:    g = 7'h6F;
      5'd10:   g = 7'h77;
      5'd11:   g = 7'h7C;
      5'd12:   g = 7'h39;
      5'd13:   g = 7'h5E;
      5'd14:   g = 7'h79;
      5'd15:   g = 7'h71;
      5'd17:   g = 7'h40;
      5'd18:   g = 7'h76;
      5'd19:   g = 7'h38;
      5'd20:   g = 7'h73;
      5'd21:   g = 7'h3E;
      5'd22:   g = 7'h50;
      5'd23:   g = 7'h54;
      5'd24:   g = 7'h5C;
      5'd25:   g = 7'h08;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  assign slot_end  = (cnt == CW'(PRESCALE - 1));
  assign frame_end = slot_end && (state == DIG2);

  // With no blanking configured the compare would be constant, so drop it.
  generate
    if (BLANK > 0) begin : g_blank
      assign blank_ph = (cnt < CW'(BLANK));
    end else begin : g_noblank
      assign blank_ph = 1'b0;
    end
  endgenerate

`ifdef SEG_DIM_EN
  logic [1:0] p;

  // Free-running duty-cycle phase for dimming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) p <= 2'd0;
    else        p <= p + 2'd1;
  end

  assign dim_on = ({1'b0, p} < (3'd4 - {1'b0, dim}));
`else
  assign dim_on = 1'b1;
`endif

  // Slot counter: wraps at the end of every digit slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cnt <= '0;
    else if (slot_end) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  // Digit-index state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DIG0;
    else        state <= state_nxt;
  end

  // Advance to the next digit at the end of each slot.
  always_comb begin
    state_nxt = state;
    if (slot_end) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        default: state_nxt = DIG0;
      endcase
    end
  end

  // Shadow the character codes only on the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh0 <= CODE_BLANK;
      sh1 <= CODE_BLANK;
      sh2 <= CODE_BLANK;
    end else if (frame_end) begin
      sh0 <= hex0;
      sh1 <= hex1;
      sh2 <= hex2;
    end
  end

  // Pick the shadowed code for the digit currently being scanned.
  always_comb begin
    case (state)
      DIG0:    sel_code = sh0;
      DIG1:    sel_code = sh1;
      default: sel_code = sh2;
    endcase
  end

  // Output decode; reset gates everything dark without waiting for a clock.
  always_comb begin
    seg        = 8'hFF;
    digit_en   = 3'b111;
    frame_tick = reset && frame_end;
    if (reset && !blank_ph && dim_on) begin
      seg = {1'b1, ~glyph(sel_code)};
      case (state)
        DIG0:    digit_en = 3'b110;
        DIG1:    digit_en = 3'b101;
        default: digit_en = 3'b011;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with PRESCALE=8, BLANK=2.
// One frame is 24 clocks; expected glyphs are hand-decoded constants.
module tb_seven_seg_scan_driver;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 3 * PRESCALE;

  logic       clk;
  logic       reset;
  logic [4:0] hex2, hex1, hex0;
  logic [7:0] seg;
  logic [2:0] digit_en;
  logic       frame_tick;
`ifdef SEG_DIM_EN
  logic [1:0] dim;
`endif

  int errors = 0;
  int checks = 0;

  seven_seg_scan_driver #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0),
`ifdef SEG_DIM_EN
    .dim        (dim),
`endif
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int pos, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
    end
  endtask

  // Walk one full frame from slot 0 cnt 0, checking every cycle.
  // Optionally changes hex0 at frame position chg_pos.
  task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input int chg_pos, input logic [4:0] chg_h0);
    int slot, c;
    logic [7:0] e_seg;
    logic [2:0] e_en;
    for (int pos = 0; pos < FRAME; pos++) begin
      slot = pos / PRESCALE;
      c    = pos % PRESCALE;
      if (pos == chg_pos) hex0 = chg_h0;
      if (c < BLANK) begin
        e_en  = 3'b111;
        e_seg = 8'hFF;
      end else begin
        e_en  = 3'b111 & ~(3'b001 << slot);
        e_seg = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
      end
      chk("seg", pos, seg, e_seg);
      chk("digit_en", pos, {5'd0, digit_en}, {5'd0, e_en});
      chk("frame_tick", pos, {7'd0, frame_tick}, {7'd0, 1'(pos == FRAME - 1)});
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    hex0  = 5'd0;
    hex1  = 5'd1;
    hex2  = 5'd8;
`ifdef SEG_DIM_EN
    dim   = 2'd0;
`endif

    // Held in reset for three cycles: dark outputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_seg", i, seg, 8'hFF);
      chk("rst_en", i, {5'd0, digit_en}, 8'h07);
      chk("rst_tick", i, {7'd0, frame_tick}, 8'h00);
    end
    reset = 1'b1;

    // First frame after release shows blank shadows; tick on the 24th cycle.
    check_frame(8'hFF, 8'hFF, 8'hFF, -1, 5'd0);
    // Digits 0,1,8; hex0 changes to '-' mid-frame with no visible effect.
    check_frame(8'hC0, 8'hF9, 8'h80, PRESCALE + 4, 5'd17);
    // New hex0 appears; hex1 changes to 26 for the following frame.
    hex1 = 5'd26;
    check_frame(8'hBF, 8'hF9, 8'h80, -1, 5'd0);
    hex1 = 5'd16;
    check_frame(8'hBF, 8'hFF, 8'h80, -1, 5'd0);
    check_frame(8'hBF, 8'hFF, 8'h80, -1, 5'd0);

    // Run to slot 2, cnt 5, then reset asynchronously between edges.
    for (int i = 0; i < 2 * PRESCALE + 5; i++) @(negedge clk);
    chk("pre_rst_seg", 21, seg, 8'h80);
    chk("pre_rst_en", 21, {5'd0, digit_en}, 8'h03);
    #1 reset = 1'b0;
    #1;
    chk("async_seg", 21, seg, 8'hFF);
    chk("async_en", 21, {5'd0, digit_en}, 8'h07);
    chk("async_tick", 21, {7'd0, frame_tick}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("hold_en", 0, {5'd0, digit_en}, 8'h07);
    reset = 1'b1;

    // Scan restarts at digit 0 with blank shadows, then shows current inputs.
    check_frame(8'hFF, 8'hFF, 8'hFF, -1, 5'd0);
    check_frame(8'hBF, 8'hFF, 8'h80, -1, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
